// File: rtl/sublime_wavetable_reader.sv
// Wavetable reader: fetches two adjacent table entries for an oscillator
// phase address and linearly interpolates between them using the fractional
// phase bits.
//
//   state  | meaning
//   -------+--------------------------------------------------------
//   IDLE   | waiting for a start strobe; index/fraction latched on start
//   READ0  | requesting entry at index, capturing s0 on ack
//   READ1  | requesting entry at index+1 (wrapping), capturing s1 on ack
//   INTERP | computing the interpolated sample, pulsing sample_valid
module sublime_wavetable_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [31:0]                  wave_addr,
    output logic                         mem_rd,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic                         mem_ack,
    input  logic signed [DATA_WIDTH-1:0] mem_data,
    output logic signed [DATA_WIDTH-1:0] sample_out,
    output logic                         sample_valid,
    output logic                         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ0  = 2'd1,
        READ1  = 2'd2,
        INTERP = 2'd3
    } state_t;

    // Product width: (DATA_WIDTH+1)-bit difference times 9-bit zero-extended fraction.
    localparam int PW = DATA_WIDTH + 9;

    state_t                         state;
    state_t                         state_nxt;
    logic [ADDR_WIDTH-1:0]          index_q;
    logic [7:0]                     frac_q;
    logic signed [DATA_WIDTH-1:0]   s0_q;
    logic signed [DATA_WIDTH-1:0]   s1_q;

    logic signed [DATA_WIDTH:0]     diff;
    logic signed [PW-1:0]           diff_ext;
    logic signed [PW-1:0]           frac_ext;
    logic signed [PW-1:0]           prod;
    logic signed [PW-1:0]           interp;
    logic signed [DATA_WIDTH-1:0]   interp_res;
    logic                           unused_bits;

    // Low phase bits beyond the fraction and the interpolation headroom are intentionally dropped.
    assign unused_bits = ^{wave_addr, interp};

    assign busy = (state != IDLE);

    // State register; reset drops any outstanding request at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and memory request decode; request held until ack.
    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        case (state)
            IDLE: begin
                if (start) state_nxt = READ0;
            end
            READ0: begin
                mem_rd   = 1'b1;
                mem_addr = index_q;
                if (mem_ack) state_nxt = READ1;
            end
            READ1: begin
                mem_rd   = 1'b1;
                mem_addr = index_q + ADDR_WIDTH'(1);
                if (mem_ack) state_nxt = INTERP;
            end
            INTERP: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Interpolation: s0 + floor((s1 - s0) * frac / 256); result stays within [s0, s1].
    always_comb begin
        diff       = {s1_q[DATA_WIDTH-1], s1_q} - {s0_q[DATA_WIDTH-1], s0_q};
        diff_ext   = {{8{diff[DATA_WIDTH]}}, diff};
        frac_ext   = {{(PW-8){1'b0}}, frac_q};
        prod       = diff_ext * frac_ext;
        interp     = {{9{s0_q[DATA_WIDTH-1]}}, s0_q} + (prod >>> 8);
        interp_res = interp[DATA_WIDTH-1:0];
    end

    // Datapath registers: phase latch, captured entries, and output sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q      <= '0;
            frac_q       <= '0;
            s0_q         <= '0;
            s1_q         <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        index_q <= wave_addr[31 -: ADDR_WIDTH];
                        frac_q  <= wave_addr[31-ADDR_WIDTH -: 8];
                    end
                end
                READ0: begin
                    if (mem_ack) s0_q <= mem_data;
                end
                READ1: begin
                    if (mem_ack) s1_q <= mem_data;
                end
                INTERP: begin
                    sample_out   <= interp_res;
                    sample_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sublime_wavetable_reader.sv
// Scoreboard bench for sublime_wavetable_reader: a memory responder with
// configurable ack delay, and a monitor that checks each sample_valid pulse
// against queued expected samples and latencies.
module tb_sublime_wavetable_reader;

    localparam int AW = 10;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [31:0]          wave_addr = '0;
    logic                 mem_rd;
    logic [AW-1:0]        mem_addr;
    logic                 mem_ack = 1'b0;
    logic signed [DW-1:0] mem_data = '0;
    logic signed [DW-1:0] sample_out;
    logic                 sample_valid;
    logic                 busy;

    sublime_wavetable_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .wave_addr    (wave_addr),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [DW-1:0] val;
        int                   start_cyc;
        int                   lat;
    } exp_t;

    logic signed [DW-1:0] mem [0:(1<<AW)-1];
    exp_t                 exp_q[$];
    logic [AW-1:0]        addr_q[$];
    int                   ack_delay = 0;
    int                   n_checks = 0;
    int                   n_fail = 0;
    int                   n_valid = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Memory responder: checks each requested address, acks after ack_delay wait cycles.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!mem_rd) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else begin
                if (addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_request: got addr %0d, expected no request", mem_addr);
                end else begin
                    check("mem_addr", mem_addr, addr_q[0]);
                end
                if (cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    mem_data = mem[mem_addr];
                    cnt = 0;
                    if (addr_q.size() > 0) void'(addr_q.pop_front());
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every sample_valid pulse.
    initial begin
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (sample_valid) begin
                n_valid++;
                check("valid_not_consecutive", prev_v, 0);
                check("busy_low_on_valid", busy, 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got sample %0d, expected no output", sample_out);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_out", sample_out, e.val);
                    check("latency", cyc - e.start_cyc, e.lat);
                end
            end
            prev_v = sample_valid;
        end
    end

    // Drives one start strobe; returns at the falling edge after the start edge.
    task automatic issue(input logic [31:0] wa, input logic signed [DW-1:0] v, input int lat,
                         input bit push_addr, input bit push_sample);
        exp_t          e;
        logic [AW-1:0] i0;
        logic [AW-1:0] i1;
        @(negedge clk);
        start = 1'b1;
        wave_addr = wa;
        i0 = wa[31 -: AW];
        i1 = i0 + 1'b1;
        if (push_addr) begin
            addr_q.push_back(i0);
            addr_q.push_back(i1);
        end
        if (push_sample) begin
            e.val = v;
            e.start_cyc = cyc + 1;
            e.lat = lat;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got %0d pending samples, expected 0", exp_q.size());
            exp_q.delete();
            addr_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int nv;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(16 * i);

        // Reset state
        @(negedge clk);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_sample_out", sample_out, 0);
        check("rst_sample_valid", sample_valid, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Ramp: index 5, frac 0x80 -> 80 + 16*128/256 = 88
        issue(32'h0160_0000, 16'sd88, 3, 1, 1);
        drain();
        // frac 0 -> exactly s0; frac 0xFF -> 80 + floor(16*255/256) = 95
        issue(32'h0140_0000, 16'sd80, 3, 1, 1);
        drain();
        issue(32'h017F_C000, 16'sd95, 3, 1, 1);
        drain();

        // Wrap-around: index 1023 -> 0, frac 0x40: 1000 + floor(-2000*64/256) = 500
        mem[1023] = 16'sd1000;
        mem[0]    = -16'sd1000;
        issue(32'hFFD0_0000, 16'sd500, 3, 1, 1);
        drain();

        // Negative rounding: floor(-1/256) = -1
        mem[0] = 16'sd0;
        mem[1] = -16'sd1;
        issue(32'h0000_4000, -16'sd1, 3, 1, 1);
        drain();

        // Full-scale slope: 32767 + floor(-65535*128/256) = -1
        mem[10] = 16'sd32767;
        mem[11] = -16'sd32768;
        issue(32'h02A0_0000, -16'sd1, 3, 1, 1);
        drain();

        // Wait states: 3 waits per read -> latency 9, busy and request held throughout
        ack_delay = 3;
        issue(32'h0160_0000, 16'sd88, 9, 1, 1);
        for (int i = 0; i < 9; i++) begin
            check("wait_busy", busy, 1);
            if (i < 8) check("wait_mem_rd", mem_rd, 1);
            @(negedge clk);
        end
        drain();
        ack_delay = 0;

        // Start while busy: second strobe must be ignored
        nv = n_valid;
        issue(32'h0160_0000, 16'sd88, 3, 1, 1);
        start = 1'b1;
        wave_addr = 32'h02A0_0000;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        check("busy_start_single_valid", n_valid - nv, 1);

        // Reset during READ1 wait cycles
        ack_delay = 3;
        issue(32'h0160_0000, 16'sd0, 0, 1, 0);
        repeat (5) @(negedge clk);
        check("pre_rst_mem_rd", mem_rd, 1);
        check("pre_rst_mem_addr", mem_addr, 6);
        nv = n_valid;
        #2;
        rst = 1'b1;
        #1;
        check("abort_mem_rd", mem_rd, 0);
        check("abort_busy", busy, 0);
        check("abort_sample_out", sample_out, 0);
        check("abort_sample_valid", sample_valid, 0);
        addr_q.delete();
        @(negedge clk);
        rst = 1'b0;
        ack_delay = 0;
        repeat (10) @(negedge clk);
        check("abort_no_valid", n_valid - nv, 0);

        // Normal conversion after reset
        issue(32'h0160_0000, 16'sd88, 3, 1, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
